// File: rtl/sigmoid_uart_requester.sv
// -----------------------------------------------------------------------------
// sigmoid_uart_requester
//
// Host-side initiator for the sigmoid-over-UART link. The block accepts one
// operand on a valid/ready port and sends it MSB byte first through a uart_core
// transmitter. It then collects the response bytes LSB byte first into
// o_rsp_data. The result is reported with a one-cycle o_rsp_valid pulse. If the
// line goes quiet for too long, a one-cycle o_rsp_timeout pulse is raised
// instead.
//
// Ports
//   i_clk            system clock
//   i_reset          synchronous, active-high reset
//   i_req_valid      request present
//   o_req_ready      high only while idle
//   i_req_operand    operand, latched on the handshake
//   o_rsp_valid      one-cycle pulse: o_rsp_data complete
//   o_rsp_timeout    one-cycle pulse: response aborted
//   o_rsp_data       assembled response, held until the next request starts
//   o_busy           high whenever a transaction is in progress
//   o_tx_start       one-cycle start pulse to uart_core
//   o_tx_data        byte to send, valid with o_tx_start
//   i_tx_busy        uart_core transmitter busy
//   i_rx_done_tick   one-cycle byte-received strobe
//   i_rx_data        received byte, valid with i_rx_done_tick
// -----------------------------------------------------------------------------
module sigmoid_uart_requester #(
    parameter int NUM_TX_BYTES   = 2,
    parameter int NUM_RX_BYTES   = 6,
    parameter int BUSY_SETTLE    = 3,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_req_valid,
    output logic                      o_req_ready,
    input  logic [8*NUM_TX_BYTES-1:0] i_req_operand,
    output logic                      o_rsp_valid,
    output logic                      o_rsp_timeout,
    output logic [8*NUM_RX_BYTES-1:0] o_rsp_data,
    output logic                      o_busy,
    output logic                      o_tx_start,
    output logic [7:0]                o_tx_data,
    input  logic                      i_tx_busy,
    input  logic                      i_rx_done_tick,
    input  logic [7:0]                i_rx_data
);

    localparam int TXW    = 8 * NUM_TX_BYTES;
    localparam int RXW    = 8 * NUM_RX_BYTES;
    localparam int TX_CW  = $clog2(NUM_TX_BYTES + 1);
    localparam int RX_CW  = $clog2(NUM_RX_BYTES + 1);
    localparam int SET_CW = (BUSY_SETTLE > 0) ? $clog2(BUSY_SETTLE + 1) : 1;
    localparam int TO_W   = 20;

    localparam logic [TX_CW-1:0]  TX_LAST    = TX_CW'(NUM_TX_BYTES);
    localparam logic [RX_CW-1:0]  RX_LAST    = RX_CW'(NUM_RX_BYTES - 1);
    localparam logic [SET_CW-1:0] SETTLE_END = SET_CW'(BUSY_SETTLE);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_SEND    = 3'd2,
        S_RECV    = 3'd3,
        S_DONE    = 3'd4,
        S_DONE_TO = 3'd5
    } state_t;

    state_t             r_state,       w_state_next;
    logic [SET_CW-1:0]  r_settle,      w_settle_next;
    logic [TX_CW-1:0]   r_tx_cnt,      w_tx_cnt_next;
    logic [RX_CW-1:0]   r_rx_cnt,      w_rx_cnt_next;
    logic [TO_W-1:0]    r_to_cnt,      w_to_cnt_next;
    logic [TXW-1:0]     r_shift,       w_shift_next;
    logic [RXW-1:0]     r_rsp_data,    w_rsp_data_next;
    logic [7:0]         r_tx_data,     w_tx_data_next;
    logic               r_tx_start,    w_tx_start_next;
    logic               r_rsp_valid,   w_rsp_valid_next;
    logic               r_rsp_timeout, w_rsp_timeout_next;
    logic               r_req_ready,   w_req_ready_next;
    logic               r_busy,        w_busy_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_settle      <= '0;
            r_tx_cnt      <= '0;
            r_rx_cnt      <= '0;
            r_to_cnt      <= '0;
            r_shift       <= '0;
            r_rsp_data    <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_req_ready   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_settle      <= w_settle_next;
            r_tx_cnt      <= w_tx_cnt_next;
            r_rx_cnt      <= w_rx_cnt_next;
            r_to_cnt      <= w_to_cnt_next;
            r_shift       <= w_shift_next;
            r_rsp_data    <= w_rsp_data_next;
            r_tx_data     <= w_tx_data_next;
            r_tx_start    <= w_tx_start_next;
            r_rsp_valid   <= w_rsp_valid_next;
            r_rsp_timeout <= w_rsp_timeout_next;
            r_req_ready   <= w_req_ready_next;
            r_busy        <= w_busy_next;
        end
    end

    // Pulse outputs are computed for the state being entered, so they are
    // high exactly while the registered state is SEND / DONE / DONE_TO.
    always_comb begin
        w_state_next       = r_state;
        w_settle_next      = r_settle;
        w_tx_cnt_next      = r_tx_cnt;
        w_rx_cnt_next      = r_rx_cnt;
        w_to_cnt_next      = r_to_cnt;
        w_shift_next       = r_shift;
        w_rsp_data_next    = r_rsp_data;
        w_tx_data_next     = r_tx_data;
        w_tx_start_next    = 1'b0;
        w_rsp_valid_next   = 1'b0;
        w_rsp_timeout_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_shift_next    = i_req_operand;
                    w_rsp_data_next = '0;
                    w_settle_next   = '0;
                    w_tx_cnt_next   = '0;
                    w_rx_cnt_next   = '0;
                    w_to_cnt_next   = '0;
                    w_state_next    = S_SETTLE;
                end
            end

            S_SETTLE: begin
                // Give uart_core time to raise tx_busy before trusting it low.
                if (r_settle != SETTLE_END) begin
                    w_settle_next = r_settle + SET_CW'(1);
                end else if (!i_tx_busy) begin
                    w_state_next    = S_SEND;
                    w_tx_start_next = 1'b1;
                    w_tx_data_next  = r_shift[TXW-1 -: 8];
                    w_shift_next    = r_shift << 8;
                    if (r_tx_cnt != TX_LAST) begin
                        w_tx_cnt_next = r_tx_cnt + TX_CW'(1);
                    end
                end
            end

            S_SEND: begin
                if (r_tx_cnt == TX_LAST) begin
                    w_rx_cnt_next = '0;
                    w_to_cnt_next = '0;
                    w_state_next  = S_RECV;
                end else begin
                    w_settle_next = '0;
                    w_state_next  = S_SETTLE;
                end
            end

            S_RECV: begin
                // A byte arriving on the expiry cycle takes priority.
                if (i_rx_done_tick) begin
                    for (int i = 0; i < NUM_RX_BYTES; i++) begin
                        if (r_rx_cnt == RX_CW'(i)) begin
                            w_rsp_data_next[8*i +: 8] = i_rx_data;
                        end
                    end
                    w_rx_cnt_next = r_rx_cnt + RX_CW'(1);
                    w_to_cnt_next = '0;
                    if (r_rx_cnt == RX_LAST) begin
                        w_state_next     = S_DONE;
                        w_rsp_valid_next = 1'b1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_state_next       = S_DONE_TO;
                    w_rsp_timeout_next = 1'b1;
                end else begin
                    w_to_cnt_next = r_to_cnt + TO_W'(1);
                end
            end

            S_DONE:    w_state_next = S_IDLE;
            S_DONE_TO: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase

        w_req_ready_next = (w_state_next == S_IDLE);
        w_busy_next      = (w_state_next != S_IDLE);
    end

    assign o_req_ready   = r_req_ready;
    assign o_rsp_valid   = r_rsp_valid;
    assign o_rsp_timeout = r_rsp_timeout;
    assign o_rsp_data    = r_rsp_data;
    assign o_busy        = r_busy;
    assign o_tx_start    = r_tx_start;
    assign o_tx_data     = r_tx_data;

endmodule

// File: tb/tb_sigmoid_uart_requester.sv
// -----------------------------------------------------------------------------
// Directed bench for sigmoid_uart_requester, built with TIMEOUT_CYCLES=100.
// -----------------------------------------------------------------------------
module tb_sigmoid_uart_requester;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_operand;
    logic        rsp_valid;
    logic        rsp_timeout;
    logic [47:0] rsp_data;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_done_tick;
    logic [7:0]  rx_data;

    int n_total = 0;
    int n_bad   = 0;
    int tx_count = 0;
    int rv_count = 0;
    int to_count = 0;
    logic prev_tx = 1'b0;

    always #5 clk = ~clk;

    sigmoid_uart_requester #(
        .NUM_TX_BYTES   (2),
        .NUM_RX_BYTES   (6),
        .BUSY_SETTLE    (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_operand  (req_operand),
        .o_rsp_valid    (rsp_valid),
        .o_rsp_timeout  (rsp_timeout),
        .o_rsp_data     (rsp_data),
        .o_busy         (busy),
        .o_tx_start     (tx_start),
        .o_tx_data      (tx_data),
        .i_tx_busy      (tx_busy),
        .i_rx_done_tick (rx_done_tick),
        .i_rx_data      (rx_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse bookkeeping, sampled mid-cycle.
    always @(negedge clk) begin
        if (tx_start) begin
            tx_count++;
            if (prev_tx) check_eq("tx_back_to_back", 1, 0);
        end
        prev_tx = tx_start;
        if (rsp_valid) rv_count++;
        if (rsp_timeout) to_count++;
        if (rsp_valid || rsp_timeout) check_eq("valid_and_timeout", {63'd0, rsp_valid & rsp_timeout}, 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_txn(input logic [15:0] op, input string tag);
        int n = 0;
        while (!req_ready && n < 500) begin
            tick();
            n++;
        end
        check_eq({tag, "_ready"}, {63'd0, req_ready}, 1);
        req_valid   = 1'b1;
        req_operand = op;
        tick();
        req_valid   = 1'b0;
    endtask

    task automatic wait_tx(input logic [7:0] exp, input string tag);
        int n = 0;
        bit seen = 0;
        while (!seen && n < 300) begin
            tick();
            n++;
            if (tx_start) seen = 1;
        end
        check_eq({tag, "_seen"}, {63'd0, seen}, 1);
        check_eq({tag, "_data"}, {56'd0, tx_data}, {56'd0, exp});
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data      = b;
        tick();
        rx_done_tick = 1'b0;
        rx_data      = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},   {63'd0, req_ready},   1);
        check_eq({tag, "_busy"},    {63'd0, busy},        0);
        check_eq({tag, "_txstart"}, {63'd0, tx_start},    0);
        check_eq({tag, "_txdata"},  {56'd0, tx_data},     0);
        check_eq({tag, "_rvalid"},  {63'd0, rsp_valid},   0);
        check_eq({tag, "_rto"},     {63'd0, rsp_timeout}, 0);
        check_eq({tag, "_rdata"},   {16'd0, rsp_data},    0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tx0, rv0, to0;
        logic [7:0] bytes6 [6];

        reset = 1'b1; req_valid = 1'b0; req_operand = '0;
        tx_busy = 1'b0; rx_done_tick = 1'b0; rx_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // 1: basic transaction with handshake-to-first-byte latency
        tx0 = tx_count; rv0 = rv_count;
        start_txn(16'h1A2B, "t1");
        check_eq("t1_busy", {63'd0, busy}, 1);
        check_eq("t1_ready_low", {63'd0, req_ready}, 0);
        repeat (3) tick();
        check_eq("t1_no_early_tx", {63'd0, tx_start}, 0);
        tick();
        check_eq("t1_tx0_at4", {63'd0, tx_start}, 1);
        check_eq("t1_tx0_data", {56'd0, tx_data}, 64'h1A);
        tick();
        check_eq("t1_tx_one_cycle", {63'd0, tx_start}, 0);
        wait_tx(8'h2B, "t1_tx1");
        tick();
        for (int i = 1; i <= 6; i++) send_rx(8'(i));
        check_eq("t1_rvalid", {63'd0, rsp_valid}, 1);
        check_eq("t1_rdata", {16'd0, rsp_data}, 64'h060504030201);
        tick();
        check_eq("t1_rvalid_drop", {63'd0, rsp_valid}, 0);
        check_eq("t1_ready_back", {63'd0, req_ready}, 1);
        check_eq("t1_rv_pulses", 64'(rv_count - rv0), 1);
        check_eq("t1_tx_pulses", 64'(tx_count - tx0), 2);

        // 2: transmitter stays busy after the first byte
        tx0 = tx_count; rv0 = rv_count;
        start_txn(16'h1A2B, "t2");
        wait_tx(8'h1A, "t2_tx0");
        tx_busy = 1'b1;
        repeat (50) tick();
        check_eq("t2_stalled", 64'(tx_count - tx0), 1);
        tx_busy = 1'b0;
        wait_tx(8'h2B, "t2_tx1");
        tick();
        bytes6 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};
        for (int i = 0; i < 6; i++) send_rx(bytes6[i]);
        check_eq("t2_rdata", {16'd0, rsp_data}, 64'h464544434241);
        tick();
        check_eq("t2_tx_pulses", 64'(tx_count - tx0), 2);
        check_eq("t2_rv_pulses", 64'(rv_count - rv0), 1);

        // 3: only three response bytes, then timeout
        rv0 = rv_count; to0 = to_count;
        start_txn(16'h5555, "t3");
        wait_tx(8'h55, "t3_tx0");
        wait_tx(8'h55, "t3_tx1");
        tick();
        send_rx(8'hAA); send_rx(8'hBB); send_rx(8'hCC);
        repeat (TO - 1) tick();
        check_eq("t3_no_early_to", {63'd0, rsp_timeout}, 0);
        tick();
        check_eq("t3_timeout", {63'd0, rsp_timeout}, 1);
        check_eq("t3_no_valid", {63'd0, rsp_valid}, 0);
        check_eq("t3_rdata", {16'd0, rsp_data}, 64'h0000_00CC_BBAA);
        tick();
        check_eq("t3_to_drop", {63'd0, rsp_timeout}, 0);
        check_eq("t3_ready", {63'd0, req_ready}, 1);
        check_eq("t3_to_pulses", 64'(to_count - to0), 1);
        check_eq("t3_rv_pulses", 64'(rv_count - rv0), 0);

        // 4: stray bytes outside RECV, request held during RECV
        send_rx(8'hFF);
        tick();
        check_eq("t4_idle_stray", {16'd0, rsp_data}, 64'h0000_00CC_BBAA);
        tx0 = tx_count; rv0 = rv_count;
        start_txn(16'h1A2B, "t4");
        send_rx(8'hFF);
        wait_tx(8'h1A, "t4_tx0");
        wait_tx(8'h2B, "t4_tx1");
        tick();
        req_valid = 1'b1; req_operand = 16'hFFFF;
        for (int i = 0; i < 6; i++) send_rx(8'h21 + 8'(i));
        req_valid = 1'b0;
        check_eq("t4_rvalid", {63'd0, rsp_valid}, 1);
        check_eq("t4_rdata", {16'd0, rsp_data}, 64'h262524232221);
        repeat (10) tick();
        check_eq("t4_tx_pulses", 64'(tx_count - tx0), 2);
        check_eq("t4_rv_pulses", 64'(rv_count - rv0), 1);
        check_eq("t4_idle", {63'd0, busy}, 0);

        // 5: reset in the middle of RECV
        rv0 = rv_count; to0 = to_count;
        start_txn(16'h7777, "t5");
        wait_tx(8'h77, "t5_tx0");
        wait_tx(8'h77, "t5_tx1");
        tick();
        send_rx(8'h01); send_rx(8'h02);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs("t5_rst");
        repeat (5) tick();
        check_eq("t5_no_pulses", 64'((rv_count - rv0) + (to_count - to0)), 0);
        start_txn(16'h0001, "t5b");
        wait_tx(8'h00, "t5b_tx0");
        wait_tx(8'h01, "t5b_tx1");
        tick();
        for (int i = 0; i < 6; i++) send_rx(8'h10 + 8'(i));
        check_eq("t5b_rvalid", {63'd0, rsp_valid}, 1);
        check_eq("t5b_rdata", {16'd0, rsp_data}, 64'h151413121110);
        tick();

        // 6: byte lands on the expiry cycle
        rv0 = rv_count; to0 = to_count;
        start_txn(16'hABCD, "t6");
        wait_tx(8'hAB, "t6_tx0");
        wait_tx(8'hCD, "t6_tx1");
        tick();
        send_rx(8'h31);
        repeat (TO - 1) tick();
        send_rx(8'h32);
        check_eq("t6_race_no_to", {63'd0, rsp_timeout}, 0);
        for (int i = 0; i < 4; i++) send_rx(8'h33 + 8'(i));
        check_eq("t6_rvalid", {63'd0, rsp_valid}, 1);
        check_eq("t6_rdata", {16'd0, rsp_data}, 64'h363534333231);
        tick();
        check_eq("t6_to_pulses", 64'(to_count - to0), 0);
        check_eq("t6_rv_pulses", 64'(rv_count - rv0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
